// File: rtl/mux_pkg.sv
// Shared definitions for the MUX-family stream blocks: select encodings and
// default data/counter widths.
package mux_pkg;

  // Route select encodings
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Default widths shared by the stream selectors and distributors
  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_CNT_W = 4;

  // Channel identifier, handy for decoding the select bit by name
  typedef enum logic {
    CHAN_A = CH_A,
    CHAN_B = CH_B
  } chanSel_e;

endpackage

// File: rtl/stream_slot.sv
// One-entry output register for a valid/ready stream. Holds one word, drains it
// to the consumer and counts completed transfers with a wrapping counter.
module stream_slot
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  assign drain = valid_q & ready;

  // Next-state: a load always wins the slot (so drain+load keeps it full and
  // gives full throughput); a drain without load empties it. Every drain counts.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    if (drain) begin
      count_d = count_q + 1'b1;
    end
  end

  // Slot registers; reset discards any held word and clears the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/demux1to2_2bit_stream.sv
// Registered 1-to-2 stream demultiplexer: one producer is split across two
// consumers, with the destination chosen per transfer by the select bit.
// A full, stalled destination blocks the input even if the other side is free.
module demux1to2_2bit_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic     aFree, bFree;
  logic     accept;
  logic     loadA, loadB;
  chanSel_e sel;

  assign sel = chanSel_e'(s);

  // Ready decode and load steering: only the selected channel may be written,
  // and nothing is accepted while reset is high
  always_comb begin
    aFree    = ~a_valid | a_ready;
    bFree    = ~b_valid | b_ready;
    in_ready = ~reset & ((sel == CHAN_B) ? bFree : aFree);
    accept   = in_valid & in_ready;
    loadA    = accept & (sel == CHAN_A);
    loadB    = accept & (sel == CHAN_B);
  end

  stream_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) uSlotA (
    .clk  (clk),
    .reset(reset),
    .load (loadA),
    .din  (x),
    .ready(a_ready),
    .data (a),
    .valid(a_valid),
    .count(a_count)
  );

  stream_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) uSlotB (
    .clk  (clk),
    .reset(reset),
    .load (loadB),
    .din  (x),
    .ready(b_ready),
    .data (b),
    .valid(b_valid),
    .count(b_count)
  );

endmodule

// File: tb/tb_demux1to2_2bit_stream.sv
// Directed bench for demux1to2_2bit_stream: reset, routing, stall,
// head-of-line blocking, counter wrap and reset mid-operation.
module tb_demux1to2_2bit_stream;

  logic       clk;
  logic       reset;
  logic [1:0] x;
  logic       s;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] a;
  logic       a_valid;
  logic       a_ready;
  logic [1:0] b;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] a_count;
  logic [3:0] b_count;

  int assertCount = 0;
  int failCount   = 0;
  logic [1:0] sb[$];
  logic [1:0] expWord;

  demux1to2_2bit_stream dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .s       (s),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .a_count (a_count),
    .b_count (b_count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then step away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the producer side and let combinational ready settle
  task automatic applyStimulus(input logic v, input logic sel, input logic [1:0] d);
    in_valid = v;
    s        = sel;
    x        = d;
    #1;
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b11);

    // Reset held 3 cycles with a word offered
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_a_valid", a_valid, 0);
      checkOutput("rst_b_valid", b_valid, 0);
      checkOutput("rst_a", a, 0);
      checkOutput("rst_b", b, 0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("post_rst_a_valid", a_valid, 0);
    checkOutput("post_rst_a_count", a_count, 0);
    checkOutput("post_rst_b_count", b_count, 0);

    // Basic route: 01 to A, then 10 to B
    applyStimulus(1'b1, 1'b0, 2'b01);
    checkOutput("route_in_ready", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b10);
    checkOutput("route_a", a, 2'b01);
    checkOutput("route_a_valid", a_valid, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("route_a_valid_clr", a_valid, 0);
    checkOutput("route_a_count", a_count, 1);
    checkOutput("route_b", b, 2'b10);
    checkOutput("route_b_valid", b_valid, 1);
    tick();
    checkOutput("route_b_valid_clr", b_valid, 0);
    checkOutput("route_b_count", b_count, 1);

    // Stall on B
    b_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b11);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_b", b, 2'b11);
    tick();
    checkOutput("stall_in_ready2", in_ready, 0);
    checkOutput("stall_b_hold", b, 2'b11);
    checkOutput("stall_b_valid", b_valid, 1);
    checkOutput("stall_b_count", b_count, 1);
    b_ready = 1'b1;
    #1;
    checkOutput("stall_release_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("stall_b_new", b, 2'b00);
    checkOutput("stall_b_valid_kept", b_valid, 1);
    checkOutput("stall_b_count2", b_count, 2);
    tick();
    checkOutput("stall_b_count3", b_count, 3);
    checkOutput("stall_b_empty", b_valid, 0);

    // Head-of-line blocking
    a_ready = 1'b0; b_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b01);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b10);
    checkOutput("hol_a_accept", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b11);
    checkOutput("hol_a_loaded", a, 2'b10);
    checkOutput("hol_b_block", in_ready, 0);
    a_ready = 1'b1;
    #1;
    checkOutput("hol_b_block_afree", in_ready, 0);
    tick();
    checkOutput("hol_a_drained", a_valid, 0);
    checkOutput("hol_a_count", a_count, 2);
    checkOutput("hol_still_block", in_ready, 0);
    checkOutput("hol_b_stable", b, 2'b01);
    b_ready = 1'b1;
    #1;
    checkOutput("hol_b_unblock", in_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00);
    checkOutput("hol_b_next", b, 2'b11);
    checkOutput("hol_b_count", b_count, 4);
    checkOutput("hol_a_behind_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("hol_a_behind", a, 2'b00);
    checkOutput("hol_a_behind_valid", a_valid, 1);
    checkOutput("hol_b_empty", b_valid, 0);
    checkOutput("hol_b_count2", b_count, 5);
    tick();
    checkOutput("hol_a_count2", a_count, 3);

    // Clear counters, then 17 back-to-back transfers to A
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("wrap_start_count", a_count, 0);
    a_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 2'((i * 3 + 1) % 4));
      checkOutput("wrap_in_ready", in_ready, 1);
      sb.push_back(x);
      tick();
      expWord = sb.pop_front();
      checkOutput("wrap_order", a, expWord);
      checkOutput("wrap_valid", a_valid, 1);
    end
    applyStimulus(1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("wrap_a_count", a_count, 1);
    checkOutput("wrap_a_empty", a_valid, 0);

    // Reset with both slots full and stalled
    a_ready = 1'b0; b_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b01);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("mid_a_full", a_valid, 1);
    checkOutput("mid_b_full", b_valid, 1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b11);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("mid_a_valid", a_valid, 0);
    checkOutput("mid_b_valid", b_valid, 0);
    checkOutput("mid_a_count", a_count, 0);
    checkOutput("mid_b_count", b_count, 0);
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    tick();
    checkOutput("mid_a_never", a_count, 0);
    checkOutput("mid_b_never", b_count, 0);
    checkOutput("mid_a_valid2", a_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
